line_fill_unit: RTL and testbench

- Downstream refill engine behind the instruction/data caches.
- Accepts the cache's single-cycle line-refill request (`mem_read_en_o` / `mem_addr_o`) and fetches the line as NrWordsPerLine sequential 32-bit reads from a word-wide backing memory port.
- Assembles the words into one LineSize-bit line and returns it with a single-cycle valid pulse, which drives the cache's `mem_read_valid_i` / `mem_read_data_i`.

---
 rtl/line_fill_unit.sv | 69 ++++++
 tb/tb_line_fill_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/line_fill_unit.sv
// line_fill_unit: refills one cache line as sequential 32-bit reads from a word-wide memory port.
module line_fill_unit #(
  parameter int ByteOffsetBits = 4,
  parameter int NrWordsPerLine = 4,
  parameter int LineSize       = 32 * NrWordsPerLine
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                req_en_i,
  input  logic [31:0]         req_addr_i,
  output logic                resp_valid_o,
  output logic [LineSize-1:0] resp_data_o,
  output logic                busy_o,
  output logic                wmem_req_o,
  output logic [31:0]         wmem_addr_o,
  input  logic                wmem_gnt_i,
  input  logic                wmem_rvalid_i,
  input  logic [31:0]         wmem_rdata_i
);
  localparam int CntW = (NrWordsPerLine > 1) ? $clog2(NrWordsPerLine) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] base_q, base_d;
  logic [LineSize-1:0] line_q, line_d;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      line_q  <= line_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    line_d  = line_q;
    case (state_q)
      IDLE: if (req_en_i) begin
        base_d  = {req_addr_i[31:ByteOffsetBits], {ByteOffsetBits{1'b0}}};
        cnt_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: if (wmem_gnt_i) state_d = WAIT;
      WAIT: if (wmem_rvalid_i) begin
        line_d[32*cnt_q +: 32] = wmem_rdata_i;
        state_d = (cnt_q == CntW'(NrWordsPerLine - 1)) ? DONE : ISSUE;
        cnt_d   = (cnt_q == CntW'(NrWordsPerLine - 1)) ? cnt_q : cnt_q + CntW'(1);
      end
      DONE: begin
        line_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // base has its offset bits clear, so OR-ing the word offset never carries into the line address
  assign wmem_req_o   = (state_q == ISSUE);
  assign wmem_addr_o  = (state_q == ISSUE) ? (base_q | 32'({cnt_q, 2'b00})) : '0;
  assign busy_o       = (state_q != IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign resp_data_o  = (state_q == DONE) ? line_q : '0;
endmodule

// File: tb/tb_line_fill_unit.sv
// tb_line_fill_unit: directed checks of refill sequencing, stalls, reset abort and back-to-back requests.
module tb_line_fill_unit;
  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         req_en_i = 1'b0;
  logic [31:0]  req_addr_i = '0;
  logic         resp_valid_o;
  logic [127:0] resp_data_o;
  logic         busy_o;
  logic         wmem_req_o;
  logic [31:0]  wmem_addr_o;
  logic         gnt = 1'b1;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         stray = 1'b0;
  logic [31:0]  stray_data = '0;
  logic [7:0]   dbase = 8'hA0;
  int cyc = 0, t0 = 0, pulses = 0, p0 = 0, total = 0, bad = 0, lat;
  logic [127:0] data;
  logic [31:0]  addrs[$];

  line_fill_unit dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_en_i(req_en_i), .req_addr_i(req_addr_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .busy_o(busy_o),
    .wmem_req_o(wmem_req_o), .wmem_addr_o(wmem_addr_o), .wmem_gnt_i(gnt),
    .wmem_rvalid_i(mem_rvalid | stray), .wmem_rdata_i(stray ? stray_data : mem_rdata)
  );

  always #5 clk_i = ~clk_i;

  // backing memory: returns dbase + word index one cycle after each grant
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    mem_rvalid <= wmem_req_o && gnt;
    mem_rdata <= 32'(dbase) + 32'(wmem_addr_o[3:2]);
    if (wmem_req_o && gnt) addrs.push_back(wmem_addr_o);
    if (resp_valid_o) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a);
    req_en_i = 1'b1;
    req_addr_i = a;
    t0 = cyc;
    @(negedge clk_i);
    req_en_i = 1'b0;
  endtask

  task automatic wait_resp(output int l, output logic [127:0] d);
    l = -1;
    d = '0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid_o) begin
        l = cyc - t0;
        d = resp_data_o;
        return;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic chk_addrs(input string tag, input logic [31:0] b);
    chk({tag, "_n"}, 128'(addrs.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_a%0d", tag, i), (i < addrs.size()) ? addrs[i] : 32'hx, b + 32'(4 * i));
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_req", wmem_req_o, 0);
    chk("rst_addr", wmem_addr_o, 0);
    chk("rst_valid", resp_valid_o, 0);
    chk("rst_data", resp_data_o, 0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("idle_busy", busy_o, 0);

    addrs.delete(); p0 = pulses;
    start(32'h0000_1234);
    chk("b_busy", busy_o, 1);
    chk("b_req0", wmem_req_o, 1);
    chk("b_addr0", wmem_addr_o, 32'h1230);
    @(negedge clk_i);
    chk("b_wait_req", wmem_req_o, 0);
    chk("b_wait_addr", wmem_addr_o, 0);
    chk("b_wait_valid", resp_valid_o, 0);
    wait_resp(lat, data);
    chk("b_lat", lat, 9);
    chk("b_data", data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(negedge clk_i);
    chk("b_post_valid", resp_valid_o, 0);
    chk("b_post_data", resp_data_o, 0);
    chk("b_post_busy", busy_o, 0);
    chk("b_pulses", pulses - p0, 1);
    chk_addrs("b", 32'h1230);

    addrs.delete();
    start(32'h0000_1234);
    repeat (3) @(negedge clk_i);
    gnt = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk_i);
      chk($sformatf("s_req_t%0d", k), wmem_req_o, 1);
      chk($sformatf("s_addr_t%0d", k), wmem_addr_o, 32'h1238);
    end
    gnt = 1'b1;
    wait_resp(lat, data);
    chk("s_lat", lat, 12);
    chk("s_data", data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(negedge clk_i);
    chk_addrs("s", 32'h1230);

    addrs.delete(); p0 = pulses;
    start(32'h0000_1234);
    repeat (3) @(negedge clk_i);
    req_en_i = 1'b1;
    req_addr_i = 32'hFFFF_FFF0;
    @(negedge clk_i);
    req_en_i = 1'b0;
    wait_resp(lat, data);
    chk("q_lat", lat, 9);
    chk("q_data", data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    repeat (4) @(negedge clk_i);
    chk("q_pulses", pulses - p0, 1);
    chk("q_busy", busy_o, 0);
    chk_addrs("q", 32'h1230);

    p0 = pulses;
    start(32'h0000_1234);
    repeat (3) @(negedge clk_i);
    chk("r_pre_busy", busy_o, 1);
    chk("r_pre_req", wmem_req_o, 0);
    rstn_i = 1'b0;
    #1;
    chk("r_in_busy", busy_o, 0);
    chk("r_in_valid", resp_valid_o, 0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    stray = 1'b1;
    stray_data = 32'hDEAD_BEEF;
    @(negedge clk_i);
    stray = 1'b0;
    chk("r_stray_busy", busy_o, 0);
    chk("r_stray_req", wmem_req_o, 0);
    repeat (12) @(negedge clk_i);
    chk("r_pulses", pulses - p0, 0);
    chk("r_idle_busy", busy_o, 0);
    addrs.delete();
    start(32'h0000_1234);
    wait_resp(lat, data);
    chk("r_next_lat", lat, 9);
    chk("r_next_data", data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(negedge clk_i);
    chk_addrs("r", 32'h1230);

    start(32'h0000_1234);
    wait_resp(lat, data);
    chk("bb_first", data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    dbase = 8'hB0;
    @(negedge clk_i);
    addrs.delete();
    start(32'h0000_0400);
    chk("bb_start_req", wmem_req_o, 1);
    chk("bb_start_addr", wmem_addr_o, 32'h400);
    wait_resp(lat, data);
    chk("bb_lat", lat, 9);
    chk("bb_data", data, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    @(negedge clk_i);
    chk_addrs("bb", 32'h400);

    dbase = 8'hC0;
    addrs.delete();
    start(32'h0000_03FF);
    wait_resp(lat, data);
    chk("le_lat", lat, 9);
    chk("le_data", data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    @(negedge clk_i);
    chk_addrs("le", 32'h3F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
